// File: rtl/coeff_readback_tx_if.sv
// PIO handshake bundle between the coefficient readback transmitter and software.
//   to_hw_sig  : software command (0 idle, 1 ack, 2 request readback, F abort)
//   to_sw_sig  : transmitter status (00 idle, 01 word valid, 10 last word valid, 11 aborted)
//   data_out   : current coefficient word, raw 18-bit pattern
//   word_index : index of the current word, 0..4
// master = transmitter side, slave = software/PIO side.
interface coeff_readback_tx_if;
  logic [3:0]  to_hw_sig;
  logic [1:0]  to_sw_sig;
  logic [17:0] data_out;
  logic [2:0]  word_index;

  modport master (
    input  to_hw_sig,
    output to_sw_sig,
    output data_out,
    output word_index
  );

  modport slave (
    output to_hw_sig,
    input  to_sw_sig,
    input  data_out,
    input  word_index
  );
endinterface

// File: rtl/coeff_readback_tx.sv
// Coefficient readback transmitter.
// Snapshots the five active biquad coefficients (b0, b1, b2, a1, a2) and streams them one word
// at a time to software over the to_sw_sig/to_hw_sig PIO handshake.
// Ports:
//   Clk, Reset_n   : clock, asynchronous active-low reset
//   start          : hardware readback request, honoured in IDLE only
//   b0..a2         : live coefficients (18-bit signed)
//   pio            : PIO handshake bundle (master side)
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse when a transfer completes
//   error          : sticky timeout flag, cleared on the next LOAD
// All outputs are registered.
module coeff_readback_tx #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       start,
  input  logic signed [17:0]         b0,
  input  logic signed [17:0]         b1,
  input  logic signed [17:0]         b2,
  input  logic signed [17:0]         a1,
  input  logic signed [17:0]         a2,
  coeff_readback_tx_if.master        pio,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] CmdIdle  = 4'h0;
  localparam logic [3:0] CmdAck   = 4'h1;
  localparam logic [3:0] CmdReq   = 4'h2;
  localparam logic [3:0] CmdAbort = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StRelease,
    StDone,
    StAbort
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  to_hw_q;
  logic [17:0] shadow_q [5];
  logic [17:0] shadow_d [5];
  logic [17:0] data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  idx_nxt;
  logic        err_q, err_d;
  cnt_t        cnt_q, cnt_d;
  logic [1:0]  to_sw_q, to_sw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    idx_d    = idx_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (start || (to_hw_q == CmdReq)) state_d = StLoad;
      end
      StLoad: begin
        shadow_d[0] = b0;
        shadow_d[1] = b1;
        shadow_d[2] = b2;
        shadow_d[3] = a1;
        shadow_d[4] = a2;
        idx_d       = 3'd0;
        err_d       = 1'b0;
        // First word comes straight from the live input, the shadow is only valid next cycle.
        data_d      = b0;
        state_d     = (to_hw_q == CmdAbort) ? StAbort : StSend;
      end
      StSend: begin
        // Software abort outranks the timeout and the ack.
        if (to_hw_q == CmdAbort) begin
          state_d = StAbort;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StAbort;
        end else if (to_hw_q == CmdAck) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (to_hw_q == CmdAbort) begin
          state_d = StAbort;
        end else if (cnt_q == CntMax) begin
          err_d   = 1'b1;
          state_d = StAbort;
        end else if (to_hw_q == CmdIdle) begin
          if (idx_q == 3'd4) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_nxt;
            data_d  = shadow_q[idx_nxt];
            state_d = StSend;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StAbort: begin
        if (to_hw_q == CmdIdle) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Cleared on every state change, so each entry to SEND/RELEASE starts a fresh window.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StSend) || (state_q == StRelease)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    case (state_d)
      StSend:  to_sw_d = (idx_d == 3'd4) ? 2'b10 : 2'b01;
      StAbort: to_sw_d = 2'b11;
      default: to_sw_d = 2'b00;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      to_hw_q <= '0;
      for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      to_sw_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_hw_q  <= pio.to_hw_sig;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      to_sw_q  <= to_sw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pio.to_sw_sig  = to_sw_q;
  assign pio.data_out   = data_q;
  assign pio.word_index = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule
